// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX-stage forwarding, load-use and memory-busy stalls,
// branch flushes, memory-wait timeout and saturating performance counters.
module hazard_unit #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic [1:0]           ResultSrcE,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 PCSrcE,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 MemTimeout,
  output logic [CNT_WIDTH-1:0] StallCycles,
  output logic [CNT_WIDTH-1:0] LoadUseCount
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               state_reg;
  logic [WAIT_W-1:0]    wait_cnt_reg;
  logic                 timeout_reg;
  logic [CNT_WIDTH-1:0] stall_cnt_reg;
  logic [CNT_WIDTH-1:0] lu_cnt_reg;

  logic                 mem_stall;
  logic                 lw_stall;
  logic                 lu_take;
  logic [4:0]           rs_e [2];
  logic [1:0]           fwd  [2];

  assign rs_e[0] = Rs1E;
  assign rs_e[1] = Rs2E;

  // Memory stage has priority over Writeback since it holds the younger result.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd[gi] = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi]))
          fwd[gi] = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi]))
          fwd[gi] = 2'b01;
      end
    end
  endgenerate

  assign ForwardAE = rst_n ? fwd[0] : 2'b00;
  assign ForwardBE = rst_n ? fwd[1] : 2'b00;

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));

  assign mem_stall = ((state_reg == S_IDLE) && MemReqM && !MemReadyM && !timeout_reg) ||
                     ((state_reg == S_WAIT) && !MemReadyM);

  assign lu_take   = rst_n && !mem_stall && !PCSrcE && lw_stall;

  // A pending branch or load-use stays frozen in D/E while memory stalls the pipe.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst_n) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        state_reg    <= S_IDLE;
        wait_cnt_reg <= '0;
        timeout_reg  <= 1'b1;
      end else begin
        state_reg    <= S_WAIT;
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
    end else begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      lu_cnt_reg    <= '0;
    end else begin
      if (StallF && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      if (lu_take && (lu_cnt_reg != '1))
        lu_cnt_reg <= lu_cnt_reg + CNT_WIDTH'(1);
    end
  end

  assign MemTimeout   = timeout_reg;
  assign StallCycles  = stall_cnt_reg;
  assign LoadUseCount = lu_cnt_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use, branch flush, memory wait,
// timeout and asynchronous reset behaviour.
module tb_hazard_unit;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          MemTimeout;
  logic [CW-1:0] StallCycles, LoadUseCount;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_unit #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles), .LoadUseCount(LoadUseCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1ns after the rising edge; checks sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_stalls(input string tag, input logic [6:0] exp);
    chk(tag, {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = '0;

    // Reset: forwarding conditions present but outputs must be forced.
    RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5;
    settle();
    chk_stalls("reset_ctl", 7'b0000_111);
    chk("reset_fwdA", 32'(ForwardAE), 32'd0);
    chk("reset_cnt", {StallCycles, LoadUseCount}, 32'd0);
    chk("reset_tmo", 32'(MemTimeout), 32'd0);
    tick();
    rst_n = 1'b1;

    // Forwarding priority and gating.
    RdW = 5'd5; RegWriteW = 1'b1; Rs2E = 5'd9;
    settle();
    chk("fwdA_M", 32'(ForwardAE), 32'd2);
    chk("fwdB_none", 32'(ForwardBE), 32'd0);
    chk_stalls("fwd_ctl", 7'b0000_000);
    Rs2E = 5'd5;
    settle();
    chk("fwdB_M", 32'(ForwardBE), 32'd2);
    RdM = 5'd0;
    settle();
    chk("fwdA_W", 32'(ForwardAE), 32'd1);
    RegWriteW = 1'b0;
    settle();
    chk("fwdA_none", 32'(ForwardAE), 32'd0);
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b0; Rs1E = 5'd0; Rs2E = 5'd0;

    // Load-use for one cycle.
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    settle();
    chk_stalls("lw_ctl", 7'b1100_010);
    chk("lw_cnt_pre", 32'(LoadUseCount), 32'd0);
    tick();
    RdE = 5'd8;
    settle();
    chk_stalls("lw_drop", 7'b0000_000);
    chk("lw_cnt", 32'(LoadUseCount), 32'd1);
    chk("lw_stallcyc", 32'(StallCycles), 32'd1);
    RdE = 5'd0; Rs2D = 5'd0;
    settle();
    chk_stalls("lw_rd0", 7'b0000_000);
    ResultSrcE = 2'b00;

    // Taken branch, then branch colliding with a load-use (branch wins).
    PCSrcE = 1'b1;
    settle();
    chk_stalls("br_ctl", 7'b0000_110);
    tick();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
    settle();
    chk_stalls("br_lw_ctl", 7'b0000_110);
    tick();
    chk("br_counters", {StallCycles, LoadUseCount}, {16'd1, 16'd1});
    ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0;

    // Memory busy 3 cycles with a pending branch frozen behind it.
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk_stalls($sformatf("mem_stall%0d", i), 7'b1111_001);
      tick();
    end
    MemReadyM = 1'b1;
    settle();
    chk_stalls("mem_release", 7'b0000_110);
    tick();
    chk("mem_stallcyc", 32'(StallCycles), 32'd4);  // 1 load-use + 3 memory
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    settle();
    chk_stalls("mem_idle", 7'b0000_000);

    // Timeout after 8 consecutive stall cycles.
    MemReqM = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("tmo_stallF", 32'(StallF), 32'd1);
      if (i == 7) chk("tmo_pre", 32'(MemTimeout), 32'd0);
      tick();
    end
    chk("tmo_flag", 32'(MemTimeout), 32'd1);
    chk_stalls("tmo_drop", 7'b0000_000);
    chk("tmo_stallcyc", 32'(StallCycles), 32'd12);
    MemReqM = 1'b0;
    tick();
    MemReqM = 1'b1;
    settle();
    chk_stalls("tmo_newreq", 7'b0000_000);
    tick();
    MemReqM = 1'b0;

    // Reset clears the timeout; then reset again in the middle of a wait.
    rst_n = 1'b0;
    settle();
    chk("rst_tmo_clr", 32'(MemTimeout), 32'd0);
    tick();
    rst_n = 1'b1;
    MemReqM = 1'b1; MemReadyM = 1'b0;
    tick();
    tick();
    settle();
    chk("wait_stallF", 32'(StallF), 32'd1);
    rst_n = 1'b0;
    settle();
    chk_stalls("rst_wait_ctl", 7'b0000_111);
    chk("rst_wait_cnt", {StallCycles, LoadUseCount}, 32'd0);
    MemReqM = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk_stalls("post_rst_ctl", 7'b0000_000);
    tick();
    chk_stalls("post_rst_ctl2", 7'b0000_000);
    chk("post_rst_cnt", 32'(StallCycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
